// File: rtl/pipe_stage_reg_pkg.sv
// rtl/pipe_stage_reg_pkg.sv - shared payload layout, NOP constants and occupancy encoding for pipeline stage registers
package pipe_stage_reg_pkg;

    localparam int PC_W    = 32;
    localparam int INSTR_W = 32;

    // decode->execute: {pc, npc, instr}
    localparam int DE_W         = PC_W + PC_W + INSTR_W;
    localparam int DE_INSTR_LSB = 0;
    localparam int DE_NPC_LSB   = INSTR_W;
    localparam int DE_PC_LSB    = INSTR_W + PC_W;

    // execute->memory: {pc, instr, commit}
    localparam int EM_W          = PC_W + INSTR_W + 1;
    localparam int EM_COMMIT_LSB = 0;
    localparam int EM_INSTR_LSB  = 1;
    localparam int EM_PC_LSB     = 1 + INSTR_W;

    // memory->writeback: {pc, commit}
    localparam int MW_W          = PC_W + 1;
    localparam int MW_COMMIT_LSB = 0;
    localparam int MW_PC_LSB     = 1;

    localparam logic [PC_W-1:0]    NOP_PC     = '0;
    localparam logic [PC_W-1:0]    NOP_NPC    = 32'h0000_0004;
    localparam logic [INSTR_W-1:0] NOP_INSTR  = 32'h0000_0013;
    localparam logic               NOP_COMMIT = 1'b0;

    localparam logic [DE_W-1:0] NOP_DE = {NOP_PC, NOP_NPC, NOP_INSTR};
    localparam logic [EM_W-1:0] NOP_EM = {NOP_PC, NOP_INSTR, NOP_COMMIT};
    localparam logic [MW_W-1:0] NOP_MW = {NOP_PC, NOP_COMMIT};

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

    function automatic logic [DE_W-1:0] pack_de(
        input logic [PC_W-1:0]    pc,
        input logic [PC_W-1:0]    npc,
        input logic [INSTR_W-1:0] instr
    );
        return {pc, npc, instr};
    endfunction

endpackage

// File: rtl/pipe_stage_reg_stall_counter.sv
// rtl/pipe_stage_reg_stall_counter.sv - saturating event counter with synchronous clear for perf monitors
module pipe_stall_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - valid/ready pipeline stage register with optional skid entry, hold, flush and stall counter
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int                 DATA_W    = 64,
    parameter logic [DATA_W-1:0]  NOP_VALUE = {DATA_W{1'b0}},
    parameter int                 SKID_EN   = 1,
    parameter int                 CNT_W     = 16
) (
    input  logic              clk_i,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              hold_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [1:0]        occ_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    input  logic              stall_cnt_clr_i
);

    occ_e              state_q, state_d;
    logic [DATA_W-1:0] main_q, skid_q;
    logic              main_ld, main_from_skid, skid_ld, skid_clr;
    logic              eff_ready, out_fire, in_fire;

    assign out_valid_o = (state_q != OCC_EMPTY);
    assign out_data_o  = main_q;
    assign occ_o       = state_q;
    assign eff_ready   = out_ready_i & ~hold_i;
    assign out_fire    = out_valid_o & eff_ready;
    assign in_fire     = in_valid_i & in_ready_o;

    // With the skid entry, ready depends only on registered occupancy, breaking the ready path.
    generate
        if (SKID_EN != 0) begin : g_skid
            assign in_ready_o = (state_q != OCC_TWO);
        end else begin : g_noskid
            assign in_ready_o = ~out_valid_o | eff_ready;
        end
    endgenerate

    always_comb begin
        state_d        = state_q;
        main_ld        = 1'b0;
        main_from_skid = 1'b0;
        skid_ld        = 1'b0;
        skid_clr       = 1'b0;
        case (state_q)
            OCC_EMPTY: begin
                if (in_fire) begin
                    main_ld = 1'b1;
                    state_d = OCC_ONE;
                end
            end
            OCC_ONE: begin
                if (in_fire && out_fire) begin
                    main_ld = 1'b1;
                end else if (out_fire) begin
                    state_d = OCC_EMPTY;
                end else if (in_fire && (SKID_EN != 0)) begin
                    skid_ld = 1'b1;
                    state_d = OCC_TWO;
                end
            end
            OCC_TWO: begin
                if (out_fire) begin
                    main_from_skid = 1'b1;
                    skid_clr       = 1'b1;
                    state_d        = OCC_ONE;
                end
            end
            default: state_d = OCC_EMPTY;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= OCC_EMPTY;
            main_q  <= NOP_VALUE;
            skid_q  <= NOP_VALUE;
        end else if (flush_i) begin
            state_q <= OCC_EMPTY;
            main_q  <= NOP_VALUE;
            skid_q  <= NOP_VALUE;
        end else begin
            state_q <= state_d;
            if (main_ld) begin
                main_q <= in_data_i;
            end else if (main_from_skid) begin
                main_q <= skid_q;
            end
            if (skid_ld) begin
                skid_q <= in_data_i;
            end else if (skid_clr) begin
                skid_q <= NOP_VALUE;
            end
        end
    end

    pipe_stall_counter #(
        .CNT_W(CNT_W)
    ) u_stall_cnt (
        .clk_i(clk_i),
        .rst_n(rst_n),
        .inc  (out_valid_o & ~eff_ready),
        .clr  (stall_cnt_clr_i),
        .cnt  (stall_cnt_o)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - directed self-checking bench for pipe_stage_reg
module tb_pipe_stage_reg;

    localparam int                DW  = 16;
    localparam logic [DW-1:0]     NOP = 16'hBEEF;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush, hold, in_valid, out_ready, clr;
    logic [DW-1:0] in_data;
    logic          b_flush, b_hold, b_in_valid, b_out_ready, b_clr;
    logic [DW-1:0] b_in_data;

    logic          a_in_ready, a_out_valid;
    logic [DW-1:0] a_out_data;
    logic [1:0]    a_occ;
    logic [15:0]   a_stall;
    logic          c_in_ready, c_out_valid;
    logic [DW-1:0] c_out_data;
    logic [1:0]    c_occ;
    logic [3:0]    c_stall;
    logic          b_in_ready, b_out_valid;
    logic [DW-1:0] b_out_data;
    logic [1:0]    b_occ;
    logic [15:0]   b_stall;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(DW), .NOP_VALUE(NOP), .SKID_EN(1), .CNT_W(16)) u_a (
        .clk_i(clk), .rst_n(rst_n), .flush_i(flush), .hold_i(hold),
        .in_valid_i(in_valid), .in_ready_o(a_in_ready), .in_data_i(in_data),
        .out_valid_o(a_out_valid), .out_ready_i(out_ready), .out_data_o(a_out_data),
        .occ_o(a_occ), .stall_cnt_o(a_stall), .stall_cnt_clr_i(clr)
    );

    pipe_stage_reg #(.DATA_W(DW), .NOP_VALUE(NOP), .SKID_EN(1), .CNT_W(4)) u_c (
        .clk_i(clk), .rst_n(rst_n), .flush_i(flush), .hold_i(hold),
        .in_valid_i(in_valid), .in_ready_o(c_in_ready), .in_data_i(in_data),
        .out_valid_o(c_out_valid), .out_ready_i(out_ready), .out_data_o(c_out_data),
        .occ_o(c_occ), .stall_cnt_o(c_stall), .stall_cnt_clr_i(clr)
    );

    pipe_stage_reg #(.DATA_W(DW), .NOP_VALUE(NOP), .SKID_EN(0), .CNT_W(16)) u_b (
        .clk_i(clk), .rst_n(rst_n), .flush_i(b_flush), .hold_i(b_hold),
        .in_valid_i(b_in_valid), .in_ready_o(b_in_ready), .in_data_i(b_in_data),
        .out_valid_o(b_out_valid), .out_ready_i(b_out_ready), .out_data_o(b_out_data),
        .occ_o(b_occ), .stall_cnt_o(b_stall), .stall_cnt_clr_i(b_clr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input logic v, input logic [DW-1:0] d,
                         input logic [1:0] o, input logic r);
        chk({tag, ".valid"}, a_out_valid, v);
        chk({tag, ".data"},  a_out_data,  d);
        chk({tag, ".occ"},   a_occ,       o);
        chk({tag, ".ready"}, a_in_ready,  r);
    endtask

    logic [DW-1:0] b_drive [8];
    logic          b_rdy   [8];
    logic [DW-1:0] b_out   [8];

    initial begin
        rst_n = 1'b0;
        {flush, hold, in_valid, out_ready, clr} = '0;
        in_data = '0;
        {b_flush, b_hold, b_in_valid, b_out_ready, b_clr} = '0;
        b_in_data = '0;

        // reset state
        tick();
        tick();
        chk_a("reset", 1'b0, NOP, 2'd0, 1'b1);
        chk("reset.stall", a_stall, 32'd0);
        chk("reset.b_ready", b_in_ready, 1'b1);
        rst_n = 1'b1;

        // back-to-back stream, one-cycle latency
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_data = DW'(i);
            tick();
            chk_a($sformatf("stream%0d", i), 1'b1, DW'(i), 2'd1, 1'b1);
        end
        in_valid = 1'b0;
        tick();
        chk("stream.drain_valid", a_out_valid, 1'b0);
        chk("stream.drain_occ", a_occ, 2'd0);
        chk("stream.stall", a_stall, 32'd0);

        // backpressure fills the skid
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h000A;
        tick();
        chk_a("bp.loadA", 1'b1, 16'h000A, 2'd1, 1'b1);
        in_data = 16'h000B;
        tick();
        chk_a("bp.loadB", 1'b1, 16'h000A, 2'd2, 1'b0);
        in_valid = 1'b0;
        tick();
        chk_a("bp.heldA", 1'b1, 16'h000A, 2'd2, 1'b0);
        chk("bp.stall", a_stall, 32'd2);
        out_ready = 1'b1;
        tick();
        chk_a("bp.outB", 1'b1, 16'h000B, 2'd1, 1'b1);
        tick();
        chk("bp.empty_valid", a_out_valid, 1'b0);
        chk("bp.empty_occ", a_occ, 2'd0);
        chk("bp.stall_kept", a_stall, 32'd2);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("bp.clr", a_stall, 32'd0);

        // hazard hold with downstream ready, counter saturation on the CNT_W=4 instance
        in_valid = 1'b1;
        in_data  = 16'h0011;
        tick();
        chk_a("hold.load", 1'b1, 16'h0011, 2'd1, 1'b1);
        in_valid = 1'b0;
        hold     = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk_a("hold.5", 1'b1, 16'h0011, 2'd1, 1'b1);
        chk("hold.stall5", a_stall, 32'd5);
        chk("hold.c_stall5", c_stall, 32'd5);
        for (int i = 0; i < 15; i++) tick();
        chk("hold.stall20", a_stall, 32'h14);
        chk("hold.c_sat", c_stall, 32'hF);
        chk("hold.c_data", c_out_data, 16'h0011);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("hold.clr_prio", a_stall, 32'd0);
        chk("hold.c_clr", c_stall, 32'd0);
        hold = 1'b0;
        tick();
        chk("hold.release_occ", a_occ, 2'd0);
        chk("hold.release_stall", a_stall, 32'd0);

        // skid accepts under hold, then flush with a same-cycle input
        hold     = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'h0021;
        tick();
        in_data = 16'h0022;
        tick();
        chk_a("fl.full", 1'b1, 16'h0021, 2'd2, 1'b0);
        flush   = 1'b1;
        in_data = 16'h000C;
        tick();
        chk_a("fl.flushed", 1'b0, NOP, 2'd0, 1'b1);
        chk("fl.stall", a_stall, 32'd2);
        flush    = 1'b0;
        in_valid = 1'b0;
        tick();
        chk_a("fl.after", 1'b0, NOP, 2'd0, 1'b1);
        hold = 1'b0;
        clr  = 1'b1;
        tick();
        clr = 1'b0;

        // asynchronous reset between edges with the skid full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h0031;
        tick();
        in_data = 16'h0032;
        tick();
        chk_a("ar.full", 1'b1, 16'h0031, 2'd2, 1'b0);
        chk("ar.stall", a_stall, 32'd1);
        in_valid = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        chk_a("ar.async", 1'b0, NOP, 2'd0, 1'b1);
        chk("ar.stall_rst", a_stall, 32'd0);
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 16'h0041;
        tick();
        chk_a("ar.resume1", 1'b1, 16'h0041, 2'd1, 1'b1);
        in_data = 16'h0042;
        tick();
        chk_a("ar.resume2", 1'b1, 16'h0042, 2'd1, 1'b1);
        in_valid = 1'b0;
        tick();
        chk("ar.drain", a_occ, 2'd0);

        // single-register variant: alternating downstream ready under continuous input
        b_drive = '{16'd1, 16'd2, 16'd2, 16'd3, 16'd3, 16'd4, 16'd4, 16'd5};
        b_rdy   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        b_out   = '{16'd1, 16'd1, 16'd2, 16'd2, 16'd3, 16'd3, 16'd4, 16'd4};
        b_in_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            b_out_ready = (k % 2 == 0);
            b_in_data   = b_drive[k];
            #1;
            chk($sformatf("b.ready%0d", k), b_in_ready, b_rdy[k]);
            tick();
            chk($sformatf("b.data%0d", k), b_out_data, b_out[k]);
            chk($sformatf("b.occ%0d", k), b_occ, 2'd1);
        end
        b_out_ready = 1'b1;
        b_hold      = 1'b1;
        #1;
        chk("b.hold_ready", b_in_ready, 1'b0);
        b_hold     = 1'b0;
        b_in_valid = 1'b0;
        #1;
        chk("b.ready_free", b_in_ready, 1'b1);
        tick();
        chk("b.drain_occ", b_occ, 2'd0);
        chk("b.drain_valid", b_out_valid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised pipeline stage register. It replaces the hand-written per-stage registers between decode, execute, memory and writeback.
- Carries an arbitrary packed payload with a valid/ready handshake, an optional 2-entry skid buffer, a hazard-unit hold, and a bubble/flush that inserts a NOP payload.
- Exposes occupancy and a saturating stall-cycle counter for performance monitoring.

Parameters:
- DATA_W, 64, payload width in bits (stage fields concatenated by the instantiating stage).
- NOP_VALUE, {DATA_W{1'b0}}, payload driven on out_data_o after reset or flush (encodes nop_PC/nop_instr/nop_commit).
- SKID_EN, 1, 1 = two-entry skid buffer (in_ready_o registered); 0 = single register (in_ready_o combinational).
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk_i  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- flush_i  in  1  bubble: discard all held entries at the next edge.
- hold_i  in  1  stall from the hazard unit: blocks output transfer.
- in_valid_i  in  1  upstream payload valid.
- in_ready_o  out  1  stage can accept a payload this cycle.
- in_data_i  in  DATA_W  upstream payload.
- out_valid_o  out  1  payload on out_data_o is valid.
- out_ready_i  in  1  downstream accepts.
- out_data_o  out  DATA_W  held payload.
- occ_o  out  2  entries held (0..2).
- stall_cnt_o  out  CNT_W  saturating count of blocked cycles.
- stall_cnt_clr_i  in  1  synchronous clear of stall_cnt_o.

Behaviour:
- Transfers and definitions:
  - eff_ready = out_ready_i & ~hold_i.
  - out_fire = out_valid_o & eff_ready.
  - in_fire = in_valid_i & in_ready_o.
- Reset (rst_n=0, asynchronous):
  - out_valid_o=0, out_data_o=NOP_VALUE, skid entry empty with data NOP_VALUE.
  - occ_o=0, stall_cnt_o=0.
  - in_ready_o=1 while in reset and on release.
- Reset asserted mid-transfer drops all entries; no partial state survives.
- States when SKID_EN=1, encoded by occ: EMPTY(0), ONE(1), TWO(2). in_ready_o = (occ!=2), a pure register decode.
  - EMPTY: in_fire -> main<=in_data_i, go ONE. Otherwise stay.
  - ONE, in_fire & out_fire -> main<=in_data_i, stay ONE.
  - ONE, out_fire only -> go EMPTY; main data retains its value.
  - ONE, in_fire only -> skid<=in_data_i, go TWO.
  - ONE, neither -> hold.
  - TWO: out_fire -> main<=skid, skid cleared, go ONE. Otherwise hold.
- SKID_EN=0:
  - in_ready_o = ~out_valid_o | eff_ready (combinational).
  - TWO is unreachable; occ_o is never 2.
- Latency:
  - One cycle in_fire->out_valid_o from EMPTY.
  - Two cycles through the skid.
  - Full throughput (1 payload/cycle) in steady state.
  - Ordering is strictly FIFO.
- Stability: while out_valid_o=1 and eff_ready=0, out_data_o and out_valid_o do not change.
- hold_i:
  - Suppresses out_fire only.
  - With SKID_EN=1, the stage still accepts one payload into the skid.
  - With SKID_EN=0, the stage accepts only when EMPTY.
- flush_i:
  - Highest priority after reset.
  - Next edge: out_valid_o=0, out_data_o=NOP_VALUE, skid emptied, occ_o=0.
  - Any same-cycle in_fire is discarded. out_fire in that cycle still counts as consumed downstream.
  - flush_i together with hold_i: flush wins.
- stall_cnt_o:
  - +1 each cycle with out_valid_o & ~eff_ready.
  - Saturates at all-ones.
  - stall_cnt_clr_i sets 0; clear has priority over increment.
  - Unaffected by flush_i.
- No X propagation: all storage has a reset value; data registers load only on their enable.

Decomposition:
- Shared package/define file holds:
  - Per-stage payload widths (DE_W, EM_W, MW_W).
  - Field offsets within the payload.
  - NOP payload constants built from nop_PC/nop_nPC/nop_commit/nop_instr.
- Optional sub-module pipe_stall_counter (saturating counter with clear), reused by other perf monitors.

Test Plan:
- Reset release, SKID_EN=1, out_ready_i=1:
  - Stream in_data 0x1..0x8 back-to-back.
  - Expect out_data 0x1..0x8 on consecutive cycles, first one cycle after its in_fire.
  - in_ready_o stays 1 and occ_o stays at or below 1.
- Backpressure:
  - Load 0xA then 0xB with out_ready_i=0.
  - Expect occ_o=2, in_ready_o=0, out_data_o=0xA held stable.
  - Release: 0xA then 0xB out, in_ready_o=1 the cycle after the first out_fire.
- hold_i=1 for 5 cycles with out_valid_o=1 and out_ready_i=1:
  - Expect no output transfer and stall_cnt_o +5.
  - stall_cnt_clr_i pulse -> stall_cnt_o=0.
  - With CNT_W=4, 20 blocked cycles -> stall_cnt_o=0xF.
- flush_i asserted with occ_o=2 and in_valid_i=1 (data 0xC) on the same edge:
  - Next cycle occ_o=0, out_valid_o=0, out_data_o=NOP_VALUE.
  - 0xC never appears at the output.
- Asynchronous reset mid-stream:
  - Drop rst_n between clock edges with occ_o=2.
  - Outputs go to reset values immediately, without a clock.
  - Stream resumes correctly after release.
- SKID_EN=0:
  - out_ready_i toggling 1,0,1,0 under continuous input.
  - occ_o is never 2.
  - in_ready_o equals ~out_valid_o | eff_ready combinationally each cycle.
  - Payload order is preserved with no loss or duplication.
